instr_fetch: RTL and testbench

Instruction-fetch stage of the CO single-cycle/pipelined MIPS datapath. It sits upstream of the decoder and Sign_Extend, and consumes the sign-extended immediate those stages produce to resolve branch and jump redirects. It holds the PC and runs a req/ack handshake with instruction memory. Each fetched instruction is presented to decode under a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instr_fetch_if.sv | 30 +++
 rtl/next_pc_calc.sv | 31 +++
 rtl/instr_fetch.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_e    : fetch FSM states (S_IDLE, S_REQ, S_VALID)
//   PC_INCR          : sequential PC increment
//   RESET_PC_DEFAULT : default PC value loaded on reset
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-stage bus bundle.
//   imem_req / imem_addr        : request to instruction memory (fetch -> memory)
//   imem_ack / imem_data        : single-cycle response pulse and data (memory -> fetch)
//   instr_valid / instr / pc /
//   pc_plus4                    : instruction presented to decode (fetch -> decode)
//   instr_ready                 : decode accepts the instruction (decode -> fetch)
// master = fetch stage side, slave = memory/decode side.
interface instr_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc, pc_plus4,
        input  imem_ack, imem_data, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc, pc_plus4,
        output imem_ack, imem_data, instr_ready
    );

endinterface

// File: rtl/next_pc_calc.sv
// next_pc_calc: purely combinational redirect-target computation.
//   br_pc_i        : PC of the redirecting instruction
//   br_imm_i       : sign-extended 16-bit immediate
//   jmp_idx_i      : 26-bit jump instruction index
//   jmp_i          : jump strobe, selects the jump target over the branch target
//   br_target_o    : br_pc_i + 4 + (br_imm_i << 2), modulo 2^32
//   jmp_target_o   : {(br_pc_i + 4)[31:28], jmp_idx_i, 2'b00}
//   redir_target_o : selected redirect target
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] br_pc_i,
    input  logic [31:0] br_imm_i,
    input  logic [25:0] jmp_idx_i,
    input  logic        jmp_i,
    output logic [31:0] br_target_o,
    output logic [31:0] jmp_target_o,
    output logic [31:0] redir_target_o
);

    logic [31:0] seq_pc;

    always_comb begin
        seq_pc         = br_pc_i + PC_INCR;
        // Top two immediate bits fall off the shift; wrap-around is intended.
        br_target_o    = seq_pc + {br_imm_i[29:0], 2'b00};
        jmp_target_o   = {seq_pc[31:28], jmp_idx_i, 2'b00};
        redir_target_o = jmp_i ? jmp_target_o : br_target_o;
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS instruction-fetch stage.
// Holds the PC, runs a req/ack handshake with instruction memory and presents each fetched
// instruction to decode under valid/ready. Branch/jump redirects arriving while a request is
// outstanding are parked in a pending register and applied when the ack returns.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   bus            : instr_fetch_if.master (memory and decode handshakes)
//   br_taken_i     : taken-branch redirect strobe
//   br_pc_i        : PC of the redirecting instruction
//   br_imm_i       : sign-extended branch immediate
//   jmp_i          : jump redirect strobe (wins over br_taken_i)
//   jmp_idx_i      : jump instruction index
//   misalign_o     : sticky misaligned-redirect flag, only when FETCH_ALIGN_CHECK_EN is defined
// Optional feature macro: FETCH_ALIGN_CHECK_EN (redirects with br_pc_i[1:0] != 0 are ignored).
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    instr_fetch_if.master        bus,
    input  logic                 br_taken_i,
    input  logic [31:0]          br_pc_i,
    input  logic [31:0]          br_imm_i,
    input  logic                 jmp_i,
    input  logic [25:0]          jmp_idx_i
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                 misalign_o
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pend_vld_q, pend_vld_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;

    logic         redirect;
    logic [31:0]  redir_target;
    logic [31:0]  br_target;
    logic [31:0]  jmp_target;

    next_pc_calc u_next_pc_calc (
        .br_pc_i        (br_pc_i),
        .br_imm_i       (br_imm_i),
        .jmp_idx_i      (jmp_idx_i),
        .jmp_i          (jmp_i),
        .br_target_o    (br_target),
        .jmp_target_o   (jmp_target),
        .redir_target_o (redir_target)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic redir_misaligned;

    always_comb begin
        redir_misaligned = (br_taken_i | jmp_i) & (br_pc_i[1:0] != 2'b00);
        // Misaligned redirects are dropped entirely: no PC load, no pending entry.
        redirect         = (br_taken_i | jmp_i) & ~redir_misaligned;
        misalign_d       = misalign_q | redir_misaligned;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign redirect = br_taken_i | jmp_i;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'h0;
            instr_q    <= 32'h0;
            pc_out_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    pc_d = redir_target;
                end
                state_d = S_REQ;
            end

            S_REQ: begin
                if (bus.imem_ack) begin
                    if (redirect) begin
                        // Same-cycle redirect is newer than anything pending.
                        pc_d       = redir_target;
                        pend_vld_d = 1'b0;
                        state_d    = S_IDLE;
                    end else if (pend_vld_q) begin
                        pc_d       = pend_tgt_q;
                        pend_vld_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        instr_d  = bus.imem_data;
                        pc_out_d = pc_q;
                        state_d  = S_VALID;
                    end
                end else if (redirect) begin
                    // PC must stay put while the request is outstanding; latest redirect wins.
                    pend_vld_d = 1'b1;
                    pend_tgt_d = redir_target;
                end
            end

            S_VALID: begin
                if (redirect) begin
                    pc_d    = redir_target;
                    state_d = S_IDLE;
                end else if (bus.instr_ready) begin
                    pc_d    = pc_q + PC_INCR;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: handshake strobes decode registered state only.
    always_comb begin
        bus.imem_req    = (state_q == S_REQ);
        bus.imem_addr   = pc_q;
        bus.instr_valid = (state_q == S_VALID);
        bus.instr       = instr_q;
        bus.pc          = pc_out_q;
        bus.pc_plus4    = pc_out_q + PC_INCR;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
// A small memory responder acks each request after a programmable number of wait cycles and
// returns the bitwise inverse of the request address as the instruction word.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        jmp;
    logic [25:0] jmp_idx;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int checks = 0;
    int errors = 0;
    int lat    = 0;
    int ack_cnt = 0;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus.master),
        .br_taken_i (br_taken),
        .br_pc_i    (br_pc),
        .br_imm_i   (br_imm),
        .jmp_i      (jmp),
        .jmp_idx_i  (jmp_idx)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_o (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: updates on the falling edge so the ack is stable at the rising edge.
    always @(negedge clk) begin
        if (rst || !bus.imem_req) begin
            bus.imem_ack = 1'b0;
            ack_cnt = 0;
        end else if (ack_cnt == lat) begin
            bus.imem_ack  = 1'b1;
            bus.imem_data = ~bus.imem_addr;
            ack_cnt++;
        end else begin
            bus.imem_ack = 1'b0;
            ack_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        br_taken = 1'b0;
        jmp      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++;
            $display("FAIL reset_req got %0b want 0", bus.imem_req); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %0b want 0", bus.instr_valid); end
        checks++; if (bus.instr !== 32'h0) begin errors++;
            $display("FAIL reset_instr got %h want 0", bus.instr); end
        checks++; if (bus.pc !== 32'h0) begin errors++;
            $display("FAIL reset_pc got %h want 0", bus.pc); end
        checks++; if (bus.pc_plus4 !== 32'h4) begin errors++;
            $display("FAIL reset_pc_plus4 got %h want 4", bus.pc_plus4); end
        rst = 1'b0;
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++;
            $display("FAIL first_req got req=%0b addr=%h want 1/0", bus.imem_req,
                     bus.imem_addr); end
    endtask

    // Zero-wait memory, decode always ready: REQ/VALID alternate at 0x0, 0x4, 0x8.
    task automatic test_sequential();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(4 * i);
            checks++;
            if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0 ||
                bus.imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL seq_req[%0d] got req=%0b valid=%0b addr=%h want 1/0/%h", i,
                         bus.imem_req, bus.instr_valid, bus.imem_addr, exp_pc);
            end
            tick();
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.pc !== exp_pc ||
                bus.instr !== ~exp_pc) begin
                errors++;
                $display("FAIL seq_valid[%0d] got valid=%0b req=%0b pc=%h instr=%h want %h",
                         i, bus.instr_valid, bus.imem_req, bus.pc, bus.instr, exp_pc);
            end
            if (i < 2) tick();
        end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.pc !== 32'h8 ||
                bus.instr !== ~32'h8) begin
                errors++;
                $display("FAIL stall_hold[%0d] got valid=%0b req=%0b pc=%h instr=%h want pc 8",
                         i, bus.instr_valid, bus.imem_req, bus.pc, bus.instr);
            end
        end
        bus.instr_ready = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin errors++;
            $display("FAIL stall_resume got req=%0b addr=%h want 1/c", bus.imem_req,
                     bus.imem_addr); end
        bus.instr_ready = 1'b0;
        tick();
        checks++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'hC) begin errors++;
            $display("FAIL stall_next got valid=%0b pc=%h want 1/c", bus.instr_valid,
                     bus.pc); end
    endtask

    // Jump from S_VALID: {(0+4)[31:28], 26'h10, 2'b00} = 0x40.
    task automatic test_jump();
        jmp = 1'b1; br_pc = 32'h0; jmp_idx = 26'h10;
        tick();
        clear_redirect();
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++;
            $display("FAIL jump_idle got valid=%0b req=%0b want 0/0", bus.instr_valid,
                     bus.imem_req); end
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin errors++;
            $display("FAIL jump_req got req=%0b addr=%h want 1/40", bus.imem_req,
                     bus.imem_addr); end
        tick();
        checks++; if (bus.pc !== 32'h40 || bus.pc_plus4 !== 32'h44) begin errors++;
            $display("FAIL jump_valid got pc=%h pc_plus4=%h want 40/44", bus.pc,
                     bus.pc_plus4); end
    endtask

    // Backward branch beats ready: 0x40 + 4 + (-2 << 2) = 0x3C.
    task automatic test_branch();
        bus.instr_ready = 1'b1;
        br_taken = 1'b1; br_pc = 32'h40; br_imm = 32'hFFFF_FFFE;
        tick();
        clear_redirect();
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++;
            $display("FAIL branch_drop got valid=%0b req=%0b want 0/0", bus.instr_valid,
                     bus.imem_req); end
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3C) begin errors++;
            $display("FAIL branch_req got req=%0b addr=%h want 1/3c", bus.imem_req,
                     bus.imem_addr); end
        tick();
        checks++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h3C) begin errors++;
            $display("FAIL branch_valid got valid=%0b pc=%h want 1/3c", bus.instr_valid,
                     bus.pc); end
    endtask

    // Slow memory; two redirects while outstanding (0x200 then 0x100): latest wins,
    // the ack data is discarded and the next request goes to 0x100.
    task automatic test_pending();
        int n;
        lat = 3;
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin errors++;
            $display("FAIL pend_req got req=%0b addr=%h want 1/40", bus.imem_req,
                     bus.imem_addr); end
        br_taken = 1'b1; br_pc = 32'h1FC; br_imm = 32'h0;
        tick();
        br_pc = 32'hF0; br_imm = 32'h3;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin errors++;
            $display("FAIL pend_addr_stable got req=%0b addr=%h want 1/40", bus.imem_req,
                     bus.imem_addr); end
        tick();
        clear_redirect();
        n = 0;
        while (bus.imem_req === 1'b1 && n < 10) begin
            tick();
            n++;
            checks++;
            if (bus.instr_valid !== 1'b0 || (bus.imem_req === 1'b1 &&
                                             bus.imem_addr !== 32'h40)) begin
                errors++;
                $display("FAIL pend_wait[%0d] got valid=%0b addr=%h want 0/40", n,
                         bus.instr_valid, bus.imem_addr);
            end
        end
        checks++; if (bus.imem_req !== 1'b0) begin errors++;
            $display("FAIL pend_timeout got req=%0b want 0 within 10 cycles", bus.imem_req);
        end
        lat = 0;
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++;
            $display("FAIL pend_target got req=%0b addr=%h want 1/100", bus.imem_req,
                     bus.imem_addr); end
        bus.instr_ready = 1'b0;
        tick();
        checks++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h100 ||
                      bus.instr !== ~32'h100) begin errors++;
            $display("FAIL pend_fetch got valid=%0b pc=%h instr=%h want 1/100", bus.instr_valid,
                     bus.pc, bus.instr); end
    endtask

    // Jump and branch together: jump target {1, 26'h10, 00} = 0x1000_0040 wins.
    task automatic test_jmp_wins();
        br_taken = 1'b1; jmp = 1'b1; br_pc = 32'h1000_0000; br_imm = 32'h5;
        jmp_idx = 26'h10;
        tick();
        clear_redirect();
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1000_0040) begin
            errors++;
            $display("FAIL jmp_wins got req=%0b addr=%h want 1/10000040", bus.imem_req,
                     bus.imem_addr); end
        tick();
        checks++; if (bus.pc !== 32'h1000_0040 || bus.pc_plus4 !== 32'h1000_0044) begin
            errors++;
            $display("FAIL jmp_wins_valid got pc=%h pc_plus4=%h want 10000040/10000044",
                     bus.pc, bus.pc_plus4); end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_misalign();
        checks++; if (misalign !== 1'b0) begin errors++;
            $display("FAIL misalign_init got %0b want 0", misalign); end
        br_taken = 1'b1; br_pc = 32'h42; br_imm = 32'h0;
        tick();
        clear_redirect();
        checks++; if (misalign !== 1'b1 || bus.instr_valid !== 1'b1 ||
                      bus.pc !== 32'h1000_0040) begin errors++;
            $display("FAIL misalign_ignore got flag=%0b valid=%0b pc=%h want 1/1/10000040",
                     misalign, bus.instr_valid, bus.pc); end
        bus.instr_ready = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1000_0044 ||
                      misalign !== 1'b1) begin errors++;
            $display("FAIL misalign_sticky got req=%0b addr=%h flag=%0b want 1/10000044/1",
                     bus.imem_req, bus.imem_addr, misalign); end
        rst = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 ||
                      misalign !== 1'b0) begin errors++;
            $display("FAIL misalign_reset got req=%0b addr=%h flag=%0b want 0/0/0",
                     bus.imem_req, bus.imem_addr, misalign); end
        rst = 1'b0;
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++;
            $display("FAIL misalign_restart got req=%0b addr=%h want 1/0", bus.imem_req,
                     bus.imem_addr); end
    endtask
`endif

    initial begin
        rst             = 1'b1;
        br_taken        = 1'b0;
        br_pc           = 32'h0;
        br_imm          = 32'h0;
        jmp             = 1'b0;
        jmp_idx         = 26'h0;
        bus.instr_ready = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_data   = 32'h0;

        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_branch();
        test_pending();
        test_jmp_wins();
`ifdef FETCH_ALIGN_CHECK_EN
        test_misalign();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
